// File: rtl/serial_add_ctrl.sv
// Wide adder sequencer driving a shared 2-bit full adder, LSB pair first.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output Ovf.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic [1:0]       add_a,
    output logic [1:0]       add_b,
    output logic             add_cin,
    input  logic [1:0]       add_sum,
    input  logic             add_cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int N  = WIDTH / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             carry_q;
    logic             cout_q;
    logic [CW-1:0]    cnt_q;
    logic             run;
    logic             last;

`ifdef SERIAL_ADD_OVF_EN
    logic sign_a_q;
    logic sign_b_q;
    logic ovf_q;
`endif

    assign run       = (state_q == S_RUN);
    assign last      = (cnt_q == CW'(N - 1));
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);

    assign add_a   = run ? a_sh_q[1:0] : 2'b00;
    assign add_b   = run ? b_sh_q[1:0] : 2'b00;
    assign add_cin = run ? carry_q : 1'b0;

    // New sum pair enters at the top; after N steps the first pair sits at bit 0.
    generate
        if (WIDTH > 2) begin : g_wide
            assign sum_d = {add_sum, sum_q[WIDTH-1:2]};
        end else begin : g_narrow
            assign sum_d = add_sum;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
`ifdef SERIAL_ADD_OVF_EN
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sh_q   <= A;
                        b_sh_q   <= B;
                        carry_q  <= Cin;
                        cnt_q    <= '0;
`ifdef SERIAL_ADD_OVF_EN
                        sign_a_q <= A[WIDTH-1];
                        sign_b_q <= B[WIDTH-1];
`endif
                        state_q  <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= add_cout;
                    a_sh_q  <= a_sh_q >> 2;
                    b_sh_q  <= b_sh_q >> 2;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last) begin
                        cout_q  <= add_cout;
`ifdef SERIAL_ADD_OVF_EN
                        ovf_q   <= (sign_a_q == sign_b_q) &&
                                   (add_sum[1] != sign_a_q);
`endif
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Sum  = sum_q;
    assign Cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign Ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized bench for serial_add_ctrl against an arithmetic reference model.
// Define SERIAL_ADD_OVF_EN to also check the Ovf output.
module tb_serial_add_ctrl;

    localparam int W = 8;
    localparam int N = W / 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] Sum;
    logic         Cout;
    logic [1:0]   add_a;
    logic [1:0]   add_b;
    logic         add_cin;
    logic [1:0]   add_sum;
    logic         add_cout;

    logic         iv2 = 1'b0;
    logic         ir2;
    logic [1:0]   a2 = '0;
    logic [1:0]   b2 = '0;
    logic         c2 = 1'b0;
    logic         ov2;
    logic         or2 = 1'b0;
    logic [1:0]   s2;
    logic         co2;
    logic [1:0]   aa2;
    logic [1:0]   ab2;
    logic         ac2;
    logic [1:0]   as2;
    logic         acout2;

`ifdef SERIAL_ADD_OVF_EN
    logic Ovf;
    logic ovf2;
`endif

    always #5 clk = ~clk;

    // External 2-bit full adders
    always_comb {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {2'b00, add_cin};
    always_comb {acout2, as2} = {1'b0, aa2} + {1'b0, ab2} + {2'b00, ac2};

    serial_add_ctrl #(.WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .Cout(Cout),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
`ifdef SERIAL_ADD_OVF_EN
        , .Ovf(Ovf)
`endif
    );

    serial_add_ctrl #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv2), .in_ready(ir2),
        .A(a2), .B(b2), .Cin(c2),
        .out_valid(ov2), .out_ready(or2),
        .Sum(s2), .Cout(co2),
        .add_a(aa2), .add_b(ab2), .add_cin(ac2),
        .add_sum(as2), .add_cout(acout2)
`ifdef SERIAL_ADD_OVF_EN
        , .Ovf(ovf2)
`endif
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // {ovf, cout, sum[7:0]}
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic c);
        int s;
        s = int'(a) + int'(b) + int'(c);
        model[8:0] = s[8:0];
        model[9]   = (a[7] == b[7]) && (s[7] != a[7]);
    endfunction

    logic [9:0] sb[$];
    int         acc_cyc[$];
    int         cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (in_valid && in_ready) begin
                sb.push_back(model(A, B, Cin));
                acc_cyc.push_back(cyc);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious", 1, 0);
                end else begin
                    chk("sb_sum", Sum, sb[0][7:0]);
                    chk("sb_cout", Cout, sb[0][8]);
`ifdef SERIAL_ADD_OVF_EN
                    chk("sb_ovf", Ovf, sb[0][9]);
`endif
                    sb.pop_front();
                end
            end
        end
    end

    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input int hold);
        logic [9:0] e;
        int msk;
        e = model(a, b, ci);
        @(negedge clk);
        chk("idle_rdy", in_ready, 1);
        A = a; B = b; Cin = ci; in_valid = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = 8'($urandom); B = 8'($urandom); Cin = 1'($urandom);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            msk = (1 << (2 * k)) - 1;
            chk("add_a", add_a, (int'(a) >> (2 * k)) & 3);
            chk("add_b", add_b, (int'(b) >> (2 * k)) & 3);
            chk("add_cin", add_cin,
                ((int'(a) & msk) + (int'(b) & msk) + int'(ci)) >> (2 * k));
            chk("run_rdy", in_ready, 0);
            chk("run_vld", out_valid, 0);
        end
        @(negedge clk);
        chk("done_vld", out_valid, 1);
        chk("done_sum", Sum, e[7:0]);
        chk("done_cout", Cout, e[8]);
`ifdef SERIAL_ADD_OVF_EN
        chk("done_ovf", Ovf, e[9]);
`endif
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            A = 8'($urandom); B = 8'($urandom); Cin = 1'($urandom);
            @(negedge clk);
            chk("hold_vld", out_valid, 1);
            chk("hold_rdy", in_ready, 0);
            chk("hold_sum", Sum, e[7:0]);
            chk("hold_cout", Cout, e[8]);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rdy", in_ready, 1);
        chk("post_vld", out_valid, 0);
        chk("post_sum", Sum, e[7:0]);
        chk("post_cout", Cout, e[8]);
    endtask

    initial begin
        int t;
        int base;
        #2;
        chk("rst_rdy", in_ready, 1);
        chk("rst_vld", out_valid, 0);
        chk("rst_sum", Sum, 0);
        chk("rst_cout", Cout, 0);
        chk("rst_adda", add_a, 0);
        chk("rst_cin", add_cin, 0);
        #10;
        rst_n = 1'b1;

        do_op(8'hFF, 8'h01, 1'b0, 0);
        do_op(8'h5A, 8'h33, 1'b1, 0);
        do_op(8'hC3, 8'h7E, 1'b0, 10);
        do_op(8'h11, 8'h22, 1'b1, 0);

        // Reset during the second RUN cycle
        @(negedge clk);
        A = 8'h55; B = 8'h22; Cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_vld", out_valid, 0);
        chk("mid_sum", Sum, 0);
        chk("mid_cout", Cout, 0);
        chk("mid_rdy", in_ready, 1);
        chk("mid_adda", add_a, 0);
        chk("mid_cin", add_cin, 0);
        repeat (2) @(negedge clk);
        chk("mid_rdy2", in_ready, 1);
        rst_n = 1'b1;
        for (int i = 0; i < N + 3; i++) begin
            @(negedge clk);
            chk("no_result", out_valid, 0);
        end
        do_op(8'h10, 8'h20, 1'b0, 0);

        // Back-to-back issue with in_valid and out_ready held high
        @(negedge clk);
        base = acc_cyc.size();
        A = 8'h03; B = 8'h04; Cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        t = 0;
        while (acc_cyc.size() < base + 1 && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        A = 8'h80; B = 8'h80;
        while (acc_cyc.size() < base + 2 && t < 40) begin
            @(posedge clk);
            #1;
            t++;
        end
        in_valid = 1'b0;
        if (acc_cyc.size() >= base + 2)
            chk("b2b_gap", acc_cyc[base + 1] - acc_cyc[base], N + 2);
        else
            chk("b2b_timeout", acc_cyc.size(), base + 2);
        repeat (N + 3) @(negedge clk);

        for (int i = 0; i < 20; i++)
            do_op(8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3));

        // WIDTH=2 instance: single RUN cycle
        @(negedge clk);
        a2 = 2'd3; b2 = 2'd3; c2 = 1'b1; iv2 = 1'b1; or2 = 1'b1;
        @(posedge clk);
        #1;
        iv2 = 1'b0;
        @(negedge clk);
        chk("w2_adda", aa2, 3);
        chk("w2_cin", ac2, 1);
        chk("w2_run_vld", ov2, 0);
        @(negedge clk);
        chk("w2_vld", ov2, 1);
        chk("w2_sum", s2, 3);
        chk("w2_cout", co2, 1);
`ifdef SERIAL_ADD_OVF_EN
        chk("w2_ovf", ovf2, 0);
`endif
        @(negedge clk);
        chk("w2_rdy", ir2, 1);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Sequencer that performs a WIDTH-bit addition by driving an external 2-bit full-adder datapath (A[1:0], B[1:0], Cin → Sum[1:0], Cout) over WIDTH/2 consecutive cycles, LSB pair first, with the carry held in a register between cycles. It sits between a requester issuing wide add operations and the shared 2-bit adder instance. A valid/ready handshake on both the operand and result sides lets it reuse one small adder for wide operands.

## Interface

**Parameters**
- WIDTH, 8: operand/result width. Must be even and ≥ 2. The step count is N = WIDTH/2.

**Ports**
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand request valid
- in_ready  out  1  controller can accept operands (high only in IDLE)
- A  in  WIDTH  operand A, sampled on accept
- B  in  WIDTH  operand B, sampled on accept
- Cin  in  1  carry-in, sampled on accept
- out_valid  out  1  result valid (high only in DONE)
- out_ready  in  1  consumer accepts result
- Sum  out  WIDTH  registered result
- Cout  out  1  registered final carry
- add_a  out  2  to adder A[1:0]
- add_b  out  2  to adder B[1:0]
- add_cin  out  1  to adder Cin
- add_sum  in  2  from adder Sum[1:0]; combinational, same cycle
- add_cout  in  1  from adder Cout; combinational, same cycle
- Ovf  out  1  signed overflow; present only with SERIAL_ADD_OVF_EN

## Operation

- **State machine:** IDLE, RUN, DONE. Encoding is free.
- **IDLE:**
  - in_ready=1.
  - On in_valid: capture A→a_sh, B→b_sh, Cin→carry, clear step counter, go to RUN.
- **RUN:**
  - Drive add_a=a_sh[1:0], add_b=b_sh[1:0], add_cin=carry.
  - Each edge:
    - Shift add_sum into the top of the result shift register, right-shifting it by 2.
    - carry←add_cout.
    - a_sh and b_sh right-shift by 2.
    - Counter increments.
  - On the edge where counter==N-1: go to DONE.
  - Cout←add_cout on that same edge.
- **DONE:**
  - out_valid=1. Sum and Cout hold stable.
  - On out_ready: go to IDLE.
- **Adder port outputs:** add_a, add_b and add_cin are 0 outside RUN.
- **Arithmetic:** {Cout,Sum} = A + B + Cin, modulo 2^(WIDTH+1); Sum is unsigned WIDTH bits.
- **Operand inputs:**
  - in_valid while not IDLE is ignored; in_ready=0.
  - Operand changes after accept have no effect.
- **Result stability:** Sum/Cout change only during RUN. They keep the last result in IDLE.
- **Reset (async, any state, including mid-RUN):**
  - State→IDLE.
  - Sum=0, Cout=0, Ovf=0, out_valid=0.
  - add_a, add_b and add_cin are 0.
  - Internal registers are cleared.
  - in_ready=1 while and after reset.
  - An in-flight operation is discarded and no result is produced.

## Timing

- Accept edge T0 = in_valid && in_ready.
- RUN occupies cycles T0+1 … T0+N.
- out_valid rises after edge T0+N, i.e. N cycles after the accept edge. WIDTH=8 → 4.
- If out_ready is already high, DONE lasts exactly 1 cycle. in_ready reasserts the following cycle.
- Minimum issue interval: N+2 cycles.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid; both are decoded from state only.
- **Back-pressure:** out_ready low holds DONE indefinitely with outputs stable.

## Configuration

- **SERIAL_ADD_OVF_EN defined:**
  - Port Ovf exists.
  - On accept, register the sign bits A[WIDTH-1] and B[WIDTH-1].
  - On the final RUN edge: Ovf ← (signA==signB) && (add_sum[1]!=signA).
  - Ovf follows the same hold and reset rules as Cout.
- **Undefined:** no Ovf port and no sign registers. Everything else is identical.

## Test plan

All scenarios use WIDTH=8.

1. A=0xFF, B=0x01, Cin=0, out_ready=1 → out_valid 4 cycles after accept; Sum=0x00, Cout=1. add_a sequence is 3,3,3,3; add_b sequence is 1,0,0,0.
2. A=0x5A, B=0x33, Cin=1 → Sum=0x8E, Cout=0. With SERIAL_ADD_OVF_EN: Ovf=1.
3. out_ready held low for 10 cycles after out_valid → Sum/Cout stable, in_ready=0, a second in_valid is ignored. Then release out_ready → IDLE the next cycle, and the second operand set is accepted once in_ready=1.
4. Assert rst_n=0 in the 2nd RUN cycle → out_valid=0, Sum=0, Cout=0, in_ready=1 immediately. No result ever appears. A new op (A=0x10, B=0x20) afterwards gives Sum=0x30.
5. Back-to-back ops with in_valid and out_ready tied high → accepts spaced exactly N+2=6 cycles apart; results 0x03+0x04 → 0x07, then 0x80+0x80 → Sum=0x00, Cout=1 (Ovf=1 if enabled).
6. WIDTH=2, A=3, B=3, Cin=1 → Sum=3, Cout=1, out_valid 1 cycle after accept.
